// File: rtl/dll_rst_seq_pkg.sv
// Shared types and sizing helpers for the DLL reset/lock sequencer.
package dll_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_DLLRST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam int RETRY_W = 8;
  localparam int LOSS_W  = 8;

  // One counter serves every timed state, so it is sized for the longest one.
  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dll_rst_seq_sync.sv
// Two-flop synchronizer for asynchronous status bits such as the DLL LOCKED pin.
module dll_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/dll_rst_seq.sv
// DLL reset/lock sequencer clocked from the free-running pre-DLL reference clock.
// Define DLL_RST_SEQ_LOSS_CNT_EN to add the LOSS_CNT lock-loss counter output.
module dll_rst_seq
  import dll_rst_seq_pkg::*;
#(
  parameter int RST_PULSE     = 3,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               LOCKED,
  output logic               DLL_RST,
  output logic               SYS_RST_N,
  output logic               READY,
  output logic               FAIL,
  output logic [RETRY_W-1:0] RETRY_CNT
`ifdef DLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  LOSS_CNT
`endif
);

  localparam int CNT_W = cntWidth(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retryInc;
  logic               dllRst_q, dllRst_d;
  logic               sysRstN_q, sysRstN_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               lockS;

  dll_lock_sync u_lock_sync (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .async_i (LOCKED),
    .sync_o  (lockS)
  );

  assign retryInc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    case (state_q)
      S_DLLRST: begin
        if (cnt_q == CNT_W'(RST_PULSE - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A lock seen on the final wait cycle takes priority over the retry.
        if (lockS) begin
          state_d = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retryInc;
          if ((MAX_RETRY != 0) && (int'(retryInc) >= MAX_RETRY)) state_d = S_FAIL;
          else                                                   state_d = S_DLLRST;
        end
      end
      S_STABLE: begin
        if (!lockS)                                     state_d = S_WAIT;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1))    state_d = S_RUN;
      end
      S_RUN: begin
        if (!lockS) state_d = S_DLLRST;
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_DLLRST;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if ((state_d == S_RUN) && (state_q != S_RUN)) retry_d = '0;
    // Outputs are registered copies of what the next state implies.
    dllRst_d  = (state_d == S_DLLRST) || (state_d == S_FAIL);
    sysRstN_d = (state_d == S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_DLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      dllRst_q  <= 1'b1;
      sysRstN_q <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dllRst_q  <= dllRst_d;
      sysRstN_q <= sysRstN_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign DLL_RST   = dllRst_q;
  assign SYS_RST_N = sysRstN_q;
  assign READY     = ready_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;

`ifdef DLL_RST_SEQ_LOSS_CNT_EN
  logic [LOSS_W-1:0] lossCnt_q, lossCnt_d;

  // Counts every lock loss seen while running; survives re-entry to RUN.
  always_comb begin
    lossCnt_d = lossCnt_q;
    if ((state_q == S_RUN) && (state_d == S_DLLRST) && (lossCnt_q != '1))
      lossCnt_d = lossCnt_q + LOSS_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lossCnt_q <= '0;
    else        lossCnt_q <= lossCnt_d;
  end

  assign LOSS_CNT = lossCnt_q;
`endif

endmodule
